// File: rtl/sr_ff_checker.sv
// sr_ff_checker: golden-model checker for an SR flip-flop with sync reset.
// Optional macro SR_CHK_COMPL_EN: also checks q_bar against ~q.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   chk_en                checking enable (dropping it returns to IDLE)
//   s, r, dut_rstn        stimulus as driven to the flip-flop under check
//   q, q_bar              observed outputs of the flip-flop under check
//   exp_q                 model value of q
//   state                 IDLE=0, SYNC=1, CHECK=2, UNKNOWN=3
//   err, err_sticky       one-cycle mismatch pulse, latched mismatch flag
//   err_cnt               saturating mismatch count
//   illegal_cnt           saturating count of s=r=1 edges
//   chk_cnt               saturating count of compares
module sr_ff_checker #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 chk_en,
   input  logic                 s,
   input  logic                 r,
   input  logic                 dut_rstn,
   input  logic                 q,
   input  logic                 q_bar,
   output logic                 exp_q,
   output logic [1:0]           state,
   output logic                 err,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [7:0]           illegal_cnt,
   output logic [15:0]          chk_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      CHECK   = 2'd2,
      UNKNOWN = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic                   expq_q, expq_d;
   logic                   err_q, err_d;
   logic                   stk_q, stk_d;
   logic [ERR_CNT_W-1:0]   ecnt_q, ecnt_d;
   logic [7:0]             icnt_q, icnt_d;
   logic [15:0]            ccnt_q, ccnt_d;

   logic cmp;
   logic illegal;
   logic mism;
   logic model_nxt;

`ifdef SR_CHK_COMPL_EN
   // Case-inequality so X/Z on the observed outputs counts as a mismatch.
   assign mism = (q !== expq_q) || (q_bar !== ~q);
`else
   logic unused_qbar;
   assign unused_qbar = q_bar;
   assign mism = (q !== expq_q);
`endif

   assign cmp     = chk_en && (state_q == CHECK);
   assign illegal = chk_en && (state_q != IDLE) && dut_rstn && s && r;

   // s=r=1 never reaches here: CHECK leaves for UNKNOWN on that input.
   always_comb begin
      model_nxt = expq_q;
      if (!dut_rstn)
         model_nxt = 1'b0;
      else if (s && !r)
         model_nxt = 1'b1;
      else if (!s && r)
         model_nxt = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      expq_d  = expq_q;
      if (!chk_en) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: state_d = SYNC;
            SYNC: begin
               if (!dut_rstn) begin
                  state_d = CHECK;
                  expq_d  = 1'b0;
               end
            end
            CHECK: begin
               if (dut_rstn && s && r)
                  state_d = UNKNOWN;
               else
                  expq_d = model_nxt;
            end
            UNKNOWN: begin
               if (!dut_rstn) begin
                  state_d = CHECK;
                  expq_d  = 1'b0;
               end else if (s ^ r) begin
                  state_d = CHECK;
                  expq_d  = s;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      err_d  = cmp && mism;
      stk_d  = stk_q | err_d;
      ecnt_d = ecnt_q;
      icnt_d = icnt_q;
      ccnt_d = ccnt_q;
      if (err_d && (ecnt_q != {ERR_CNT_W{1'b1}}))
         ecnt_d = ecnt_q + 1'b1;
      if (illegal && (icnt_q != 8'hFF))
         icnt_d = icnt_q + 8'd1;
      if (cmp && (ccnt_q != 16'hFFFF))
         ccnt_d = ccnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         expq_q  <= 1'b0;
         err_q   <= 1'b0;
         stk_q   <= 1'b0;
         ecnt_q  <= '0;
         icnt_q  <= '0;
         ccnt_q  <= '0;
      end else begin
         state_q <= state_d;
         expq_q  <= expq_d;
         err_q   <= err_d;
         stk_q   <= stk_d;
         ecnt_q  <= ecnt_d;
         icnt_q  <= icnt_d;
         ccnt_q  <= ccnt_d;
      end
   end

   assign exp_q       = expq_q;
   assign state       = state_q;
   assign err         = err_q;
   assign err_sticky  = stk_q;
   assign err_cnt     = ecnt_q;
   assign illegal_cnt = icnt_q;
   assign chk_cnt     = ccnt_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// tb_sr_ff_checker: directed vector table plus corner-case sequences.
// Drives a behavioural SR flip-flop whose q/q_bar can be overridden.
module tb_sr_ff_checker;

`ifdef SR_CHK_COMPL_EN
   localparam int CE = 1;
`else
   localparam int CE = 0;
`endif

   logic       clk = 1'b0;
   logic       rst, chk_en, s, r, dut_rstn;
   logic       q, q_bar;
   logic       exp_q, err, err_sticky;
   logic [1:0] state;
   logic [3:0] err_cnt;
   logic [7:0] illegal_cnt;
   logic [15:0] chk_cnt;

   logic ffq;
   logic fe, fv, qbx;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!dut_rstn)
         ffq <= 1'b0;
      else if (s && !r)
         ffq <= 1'b1;
      else if (!s && r)
         ffq <= 1'b0;
   end

   assign q     = fe ? fv : ffq;
   assign q_bar = qbx ? q : ~q;

   sr_ff_checker #(.ERR_CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .chk_en     (chk_en),
      .s          (s),
      .r          (r),
      .dut_rstn   (dut_rstn),
      .q          (q),
      .q_bar      (q_bar),
      .exp_q      (exp_q),
      .state      (state),
      .err        (err),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt),
      .illegal_cnt(illegal_cnt),
      .chk_cnt    (chk_cnt)
   );

   typedef struct {
      logic ce, rn, s, r, fe, fv, qbx;
      int   st, eq, er, ecnt, ccnt, icnt, stk;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic ce_, rn_, s_, r_, fe_, fv_, qbx_,
                      input int st_, eq_, er_, ec_, cc_, ic_, sk_);
      vec_t v;
      v.ce = ce_; v.rn = rn_; v.s = s_; v.r = r_;
      v.fe = fe_; v.fv = fv_; v.qbx = qbx_;
      v.st = st_; v.eq = eq_; v.er = er_;
      v.ecnt = ec_; v.ccnt = cc_; v.icnt = ic_; v.stk = sk_;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      nchk++;
      if (act !== want) begin
         nerr++;
         $display("FAIL %s got=%0d want=%0d", nm, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string p, input int st_, eq_, er_,
                          ec_, cc_, ic_, sk_);
      chk({p, ".state"}, 32'(state), st_);
      chk({p, ".exp_q"}, 32'(exp_q), eq_);
      chk({p, ".err"}, 32'(err), er_);
      chk({p, ".err_cnt"}, 32'(err_cnt), ec_);
      chk({p, ".chk_cnt"}, 32'(chk_cnt), cc_);
      chk({p, ".illegal_cnt"}, 32'(illegal_cnt), ic_);
      chk({p, ".err_sticky"}, 32'(err_sticky), sk_);
   endtask

   initial begin
      //   ce rn s  r  fe fv qb   st eq er ecnt    cc ic sk
      add(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,      0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0,      0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0,      1, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0,  2, 1, 0, 0,      2, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0,  2, 1, 0, 0,      3, 0, 0);
      add(1, 1, 0, 1, 0, 0, 0,  2, 0, 0, 0,      4, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0,  2, 1, 0, 0,      5, 0, 0);
      add(1, 1, 0, 1, 0, 0, 0,  2, 0, 0, 0,      6, 0, 0);
      add(1, 1, 1, 1, 0, 0, 0,  3, 0, 0, 0,      7, 1, 0);
      add(1, 1, 0, 0, 1, 1, 0,  3, 0, 0, 0,      7, 1, 0);
      add(1, 1, 1, 1, 0, 0, 0,  3, 0, 0, 0,      7, 2, 0);
      add(1, 1, 0, 1, 0, 0, 0,  2, 0, 0, 0,      7, 2, 0);
      add(1, 1, 0, 0, 1, 1, 0,  2, 0, 1, 1,      8, 2, 1);
      add(1, 1, 0, 0, 0, 0, 0,  2, 0, 0, 1,      9, 2, 1);
      add(1, 1, 1, 0, 0, 0, 0,  2, 1, 0, 1,     10, 2, 1);
      add(1, 1, 0, 0, 0, 0, 1,  2, 1, CE, 1+CE, 11, 2, 1);
      add(1, 1, 0, 0, 0, 0, 0,  2, 1, 0, 1+CE,  12, 2, 1);
      add(0, 1, 0, 0, 1, 0, 0,  0, 1, 0, 1+CE,  12, 2, 1);
      add(1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 1+CE,  12, 2, 1);
      add(1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 1+CE,  12, 2, 1);
      add(1, 1, 1, 1, 0, 0, 0,  1, 1, 0, 1+CE,  12, 3, 1);
      add(1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1+CE,  12, 3, 1);
      add(1, 1, 0, 0, 0, 0, 0,  2, 0, 0, 1+CE,  13, 3, 1);
      add(1, 1, 1, 1, 1, 1, 0,  3, 0, 1, 2+CE,  14, 4, 1);
      add(1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 2+CE,  14, 4, 1);
      add(1, 1, 0, 0, 0, 0, 0,  2, 0, 0, 2+CE,  15, 4, 1);

      // Reset with chk_en high: reset wins.
      rst = 1; chk_en = 1; dut_rstn = 0; s = 0; r = 0;
      fe = 0; fv = 0; qbx = 0;
      tick();
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      rst = 0;

      foreach (vq[i]) begin
         chk_en = vq[i].ce; dut_rstn = vq[i].rn;
         s = vq[i].s; r = vq[i].r;
         fe = vq[i].fe; fv = vq[i].fv; qbx = vq[i].qbx;
         tick();
         chk_all($sformatf("row%0d", i), vq[i].st, vq[i].eq, vq[i].er,
                 vq[i].ecnt, vq[i].ccnt, vq[i].icnt, vq[i].stk);
      end

      // q stuck wrong for 20 compares: 4-bit err_cnt must stop at 15.
      chk_en = 1; dut_rstn = 1; s = 0; r = 0;
      fe = 1; fv = 1; qbx = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (k == 9)
            chk("sat.mid", 32'(err_cnt), 12 + CE);
      end
      chk("sat.err_cnt", 32'(err_cnt), 15);
      chk("sat.err", 32'(err), 1);
      chk("sat.chk_cnt", 32'(chk_cnt), 35);
      chk("sat.state", 32'(state), 2);

      // Reset mid-CHECK with a mismatch pending: nothing reported.
      rst = 1;
      tick();
      chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
      rst = 0;
      tick();
      chk("post.err", 32'(err), 0);
      chk("post.state", 32'(state), 1);
      chk("post.chk_cnt", 32'(chk_cnt), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/sr_ff_checker.md
SR_FF_CHECKER -- requirements
Module: sr_ff_checker

Interface
REQ-001 The block SHALL have parameter ERR_CNT_W, default 8, giving the error-counter width (legal range 4..16).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port chk_en, input, 1 bit: checking enable.
REQ-005 The block SHALL have the port s, input, 1 bit: set input, as driven to the flip-flop under check.
REQ-006 The block SHALL have the port r, input, 1 bit: reset input, as driven to the flip-flop under check.
REQ-007 The block SHALL have the port dut_rstn, input, 1 bit: the active-low reset of the flip-flop under check, as driven to it.
REQ-008 The block SHALL have the port q, input, 1 bit: the observed q of the flip-flop under check.
REQ-009 The block SHALL have the port q_bar, input, 1 bit: the observed q_bar of the flip-flop under check.
REQ-010 The block SHALL have the port exp_q, output, 1 bit: the expected q from the golden model.
REQ-011 The block SHALL have the port state, output, 2 bits: the FSM state, encoded IDLE=0, SYNC=1, CHECK=2, UNKNOWN=3.
REQ-012 The block SHALL have the port err, output, 1 bit: a one-cycle mismatch pulse.
REQ-013 The block SHALL have the port err_sticky, output, 1 bit: a latched indication that any mismatch has occurred.
REQ-014 The block SHALL have the port err_cnt, output, ERR_CNT_W bits: a saturating mismatch count.
REQ-015 The block SHALL have the port illegal_cnt, output, 8 bits: a saturating count of s=r=1 events.
REQ-016 The block SHALL have the port chk_cnt, output, 16 bits: a saturating count of compares performed.

Function
REQ-017 The model SHALL be as follows: on each edge, the next exp_q is 0 if dut_rstn=0; else 1 if s=1,r=0; else 0 if s=0,r=1; else it holds for s=r=0; s=r=1 is undefined.
REQ-018 IDLE SHALL go to SYNC on an edge with chk_en=1; no model update and no compare take place in IDLE.
REQ-019 SYNC SHALL go to CHECK on an edge sampling dut_rstn=0, loading exp_q=0; otherwise it stays in SYNC with no compare.
REQ-020 CHECK SHALL go to UNKNOWN on an edge sampling dut_rstn=1, s=1, r=1; otherwise it stays in CHECK and updates exp_q per REQ-017.
REQ-021 UNKNOWN SHALL go to CHECK on an edge sampling dut_rstn=0 (loading exp_q=0) or s^r=1 (loading exp_q=s); otherwise it stays in UNKNOWN with exp_q held.
REQ-022 Any state SHALL go to IDLE on an edge with chk_en=0; this has priority over all other transitions, and exp_q holds.
REQ-023 Compare SHALL be performed on an edge where state==CHECK and chk_en=1: mismatch is q != exp_q, with both values as sampled at that edge.
REQ-024 Compare latency SHALL be as follows: the stimulus sampled at edge k is checked against q at edge k+1.
REQ-025 Each compare SHALL increment chk_cnt, saturating at 16'hFFFF.
REQ-026 On a mismatch, err SHALL be 1 for exactly the cycle following the edge, err_sticky SHALL set, and err_cnt SHALL increment, saturating at all-ones.
REQ-027 illegal_cnt SHALL increment on every edge with chk_en=1, state!=IDLE, dut_rstn=1, s=1 and r=1, including repeats while in UNKNOWN; it saturates at 8'hFF.
REQ-028 The first edge after entering CHECK from SYNC SHALL compare against exp_q=0.
REQ-029 A mismatch SHALL NOT change state; checking continues.
REQ-030 A transition to UNKNOWN SHALL be evaluated at the same edge as any compare; the compare still occurs at that edge.
REQ-031 X/Z on q SHALL count as a mismatch (case-inequality) in simulation.

Reset
REQ-032 With rst=1 at an edge, state=IDLE, exp_q=0, err=0, err_sticky=0, and err_cnt, illegal_cnt and chk_cnt=0; rst has priority over chk_en.
REQ-033 Reset mid-CHECK SHALL discard the pending compare for that edge, and no err is produced.
REQ-034 err_sticky SHALL be cleared only by rst.

Configuration
REQ-035 With SR_CHK_COMPL_EN defined, the compare SHALL additionally flag a mismatch if q_bar != ~q; a mismatch on either q or q_bar at one edge produces a single err pulse and a single increment.
REQ-036 Without SR_CHK_COMPL_EN, q_bar SHALL be ignored, with no logic depending on it.

Verification
REQ-037 The bench SHALL cover: 10 ns clk, rst 1 cycle, chk_en=1, dut_rstn=0 for 2 edges, then s/r = 00, 01, 10 every 10 ns with a correct FF -> err never 1, err_cnt=0, and chk_cnt counts each CHECK edge.
REQ-038 The bench SHALL cover: a correct FF followed by s=r=1 at one edge -> state=UNKNOWN, illegal_cnt=1, no compares thereafter until s=0,r=1 is sampled, then state=CHECK and exp_q=0.
REQ-039 The bench SHALL cover: q forced to 1 while exp_q=0 for 1 edge -> err pulses for 1 cycle, err_cnt=1, err_sticky=1, and err_sticky stays 1 after q recovers.
REQ-040 The bench SHALL cover: ERR_CNT_W=4 with q stuck wrong for 20 compares -> err_cnt saturates at 4'hF.
REQ-041 The bench SHALL cover: chk_en dropped mid-CHECK, then raised with dut_rstn=1 held -> the block stays in SYNC with no compares until dut_rstn=0 is sampled.
REQ-042 The bench SHALL cover: with SR_CHK_COMPL_EN defined, q_bar forced equal to q -> err=1 and err_cnt increments; without the macro, the same stimulus gives err=0.
